// File: rtl/led_framebuf.sv
// led_framebuf: double-buffered 64x64 RGB888 frame store feeding a HUB75 scan stage.
// A raster pixel stream fills the back bank; the scan stage reads the front bank.
// Banks swap only when the scan row address wraps, so a displayed frame never tears.
//
// Ports:
//   clk          pixel clock, shared with the scan stage
//   reset        asynchronous, active-high
//   wr_valid     write pixel valid
//   wr_ready     write pixel accepted when wr_valid && wr_ready
//   wr_sof       marks the current pixel as the first of a frame (x=0,y=0)
//   wr_data      pixel {r,g,b}
//   rd_addrx     column requested by the scan stage
//   rd_addry     row pair requested by the scan stage
//   r0,g0,b0     front-bank pixel (rd_addrx, rd_addry), one cycle after address
//   r1,g1,b1     front-bank pixel (rd_addrx, rd_addry + 2**YBITS), one cycle after address
//   frame_valid  high once a complete frame has been swapped in
//   swap_pulse   one-cycle pulse on the cycle after the banks swap
module led_framebuf #(
  parameter int unsigned XBITS = 6,
  parameter int unsigned YBITS = 5,
  parameter int unsigned CBITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic               wr_sof,
  input  logic [3*CBITS-1:0] wr_data,
  input  logic [XBITS-1:0]   rd_addrx,
  input  logic [YBITS-1:0]   rd_addry,
  output logic [CBITS-1:0]   r0,
  output logic [CBITS-1:0]   g0,
  output logic [CBITS-1:0]   b0,
  output logic [CBITS-1:0]   r1,
  output logic [CBITS-1:0]   g1,
  output logic [CBITS-1:0]   b1,
  output logic               frame_valid,
  output logic               swap_pulse
);

  localparam int unsigned PW    = 3 * CBITS;
  localparam int unsigned WYW   = YBITS + 1;
  localparam int unsigned AW    = 1 + YBITS + XBITS;
  localparam int unsigned DEPTH = 2 ** AW;

  localparam logic [XBITS-1:0] X_MAX  = '1;
  localparam logic [WYW-1:0]   WY_MAX = '1;
  localparam logic [YBITS-1:0] RY_MAX = '1;

  typedef enum logic {
    FILL = 1'b0,
    WAIT = 1'b1
  } wr_state_t;

  wr_state_t        state, state_nxt;
  logic [XBITS-1:0] wx, wx_nxt;
  logic [WYW-1:0]   wy, wy_nxt;
  logic             front, front_nxt;
  logic             swap_pend, swap_pend_nxt;
  logic [YBITS-1:0] prev_addry;

  logic             boundary;
  logic             swap_now;
  logic             wr_en;
  logic [XBITS-1:0] wr_x;
  logic [WYW-1:0]   wr_y;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;

  logic [PW-1:0] ram_up [DEPTH];
  logic [PW-1:0] ram_lo [DEPTH];

  // Write FSM, raster counters and bank-swap decision.
  always_comb begin
    state_nxt     = state;
    wx_nxt        = wx;
    wy_nxt        = wy;
    swap_pend_nxt = swap_pend;
    front_nxt     = front;
    wr_en         = 1'b0;
    wr_x          = wx;
    wr_y          = wy;
    boundary      = (prev_addry == RY_MAX) && (rd_addry == '0);
    // swap_pend is the registered value, so a frame completed on the boundary
    // cycle itself waits for the next boundary.
    swap_now      = boundary && swap_pend;

    case (state)
      FILL: begin
        if (wr_valid) begin
          wr_en = 1'b1;
          if (wr_sof) begin
            // Resync: discard any partial frame and restart the raster.
            wr_x   = '0;
            wr_y   = '0;
            wx_nxt = XBITS'(1);
            wy_nxt = '0;
          end else if ((wx == X_MAX) && (wy == WY_MAX)) begin
            wx_nxt        = '0;
            wy_nxt        = '0;
            swap_pend_nxt = 1'b1;
            state_nxt     = WAIT;
          end else if (wx == X_MAX) begin
            wx_nxt = '0;
            wy_nxt = wy + WYW'(1);
          end else begin
            wx_nxt = wx + XBITS'(1);
          end
        end
      end
      WAIT: begin
        if (swap_now) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase

    if (swap_now) begin
      front_nxt     = ~front;
      swap_pend_nxt = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FILL;
      wx          <= '0;
      wy          <= '0;
      front       <= 1'b0;
      swap_pend   <= 1'b0;
      prev_addry  <= '0;
      frame_valid <= 1'b0;
      swap_pulse  <= 1'b0;
      wr_ready    <= 1'b1;
    end else begin
      state       <= state_nxt;
      wx          <= wx_nxt;
      wy          <= wy_nxt;
      front       <= front_nxt;
      swap_pend   <= swap_pend_nxt;
      prev_addry  <= rd_addry;
      frame_valid <= frame_valid | swap_now;
      swap_pulse  <= swap_now;
      wr_ready    <= (state_nxt == FILL);
    end
  end

  // Writes go to the back bank; wr_y MSB picks the lower half RAM.
  assign waddr = {~front, wr_y[YBITS-1:0], wr_x};
  assign raddr = {front, rd_addry, rd_addrx};

  always_ff @(posedge clk) begin
    if (wr_en && !wr_y[YBITS]) ram_up[waddr] <= wr_data;
    if (wr_en &&  wr_y[YBITS]) ram_lo[waddr] <= wr_data;
  end

  // Registered front-bank read; blanked until a full frame has been shown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r0 <= '0; g0 <= '0; b0 <= '0;
      r1 <= '0; g1 <= '0; b1 <= '0;
    end else if (frame_valid) begin
      {r0, g0, b0} <= ram_up[raddr];
      {r1, g1, b1} <= ram_lo[raddr];
    end else begin
      r0 <= '0; g0 <= '0; b0 <= '0;
      r1 <= '0; g1 <= '0; b1 <= '0;
    end
  end

endmodule

// File: tb/tb_led_framebuf.sv
// Bench for led_framebuf: directed steps with a reference frame model and a
// read-data scoreboard checked every clock.
module tb_led_framebuf;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_sof;
  logic [23:0] wr_data;
  logic [5:0]  rd_addrx;
  logic [4:0]  rd_addry;
  logic [7:0]  r0, g0, b0, r1, g1, b1;
  logic        frame_valid;
  logic        swap_pulse;

  led_framebuf #(.XBITS(6), .YBITS(5), .CBITS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_sof      (wr_sof),
    .wr_data     (wr_data),
    .rd_addrx    (rd_addrx),
    .rd_addry    (rd_addry),
    .r0          (r0),
    .g0          (g0),
    .b0          (b0),
    .r1          (r1),
    .g1          (g1),
    .b1          (b1),
    .frame_valid (frame_valid),
    .swap_pulse  (swap_pulse)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: images indexed y*64+x, y in 0..63.
  logic [23:0] img_front [4096];
  logic [23:0] img_back  [4096];
  bit          m_fill, m_pend, m_fv, m_pulse;
  int          m_wx, m_wy;
  logic [4:0]  m_prev_y;
  logic [47:0] exp_q [$];
  bit          scan_en;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fill   = 1'b1;
    m_pend   = 1'b0;
    m_fv     = 1'b0;
    m_pulse  = 1'b0;
    m_wx     = 0;
    m_wy     = 0;
    m_prev_y = 5'd0;
    exp_q.delete();
  endtask

  // One clock: predict, advance, compare every output, then move the scan address.
  task automatic tick();
    logic [47:0] e;
    logic [23:0] t;
    bit bnd, acc, sw;
    bnd = (m_prev_y == 5'd31) && (rd_addry == 5'd0);
    acc = wr_valid && m_fill;
    sw  = bnd && m_pend;
    if (m_fv)
      e = {img_front[int'(rd_addry) * 64 + int'(rd_addrx)],
           img_front[(int'(rd_addry) + 32) * 64 + int'(rd_addrx)]};
    else
      e = '0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (acc) begin
      if (wr_sof) begin
        img_back[0] = wr_data;
        m_wx = 1;
        m_wy = 0;
      end else begin
        img_back[m_wy * 64 + m_wx] = wr_data;
        if (m_wx == 63 && m_wy == 63) begin
          m_wx = 0; m_wy = 0; m_pend = 1'b1; m_fill = 1'b0;
        end else if (m_wx == 63) begin
          m_wx = 0; m_wy++;
        end else begin
          m_wx++;
        end
      end
    end
    if (sw) begin
      for (int i = 0; i < 4096; i++) begin
        t = img_front[i]; img_front[i] = img_back[i]; img_back[i] = t;
      end
      m_pend = 1'b0; m_fv = 1'b1; m_fill = 1'b1;
    end
    m_pulse  = sw;
    m_prev_y = rd_addry;
    chk("colour", {r0, g0, b0, r1, g1, b1}, exp_q.pop_front());
    chk("swap_pulse", 48'(swap_pulse), 48'(m_pulse));
    chk("frame_valid", 48'(frame_valid), 48'(m_fv));
    chk("wr_ready", 48'(wr_ready), 48'(m_fill));
    if (scan_en) begin
      rd_addry = rd_addry + 5'd1;
      rd_addrx = 6'($urandom);
    end
  endtask

  task automatic write_px(input logic [23:0] d, input bit sof);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_sof   = sof;
    tick();
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
  endtask

  task automatic write_pattern(input int first, input int last, input logic [7:0] tagb);
    for (int k = first; k <= last; k++)
      write_px({8'(k % 64), 8'(k / 64), tagb}, 1'b0);
  endtask

  task automatic read_chk(input int x, input int y, input logic [47:0] exp, input string tag);
    rd_addrx = 6'(x);
    rd_addry = 5'(y);
    tick();
    chk(tag, {r0, g0, b0, r1, g1, b1}, exp);
  endtask

  task automatic wait_swap(input int bound, input string tag);
    int n;
    n = 0;
    while (!swap_pulse && n < bound) begin
      tick();
      n++;
    end
    chk(tag, 48'(swap_pulse), 48'd1);
    tick();
    chk({tag, "_width"}, 48'(swap_pulse), 48'd0);
  endtask

  initial begin
    int pulses;
    reset    = 1'b0;
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
    wr_data  = '0;
    rd_addrx = '0;
    rd_addry = '0;
    scan_en  = 1'b0;

    // T1: asynchronous reset before any clock edge
    #3 reset = 1'b1;
    #1;
    chk("t1_colour", {r0, g0, b0, r1, g1, b1}, 48'd0);
    chk("t1_wr_ready", 48'(wr_ready), 48'd1);
    chk("t1_frame_valid", 48'(frame_valid), 48'd0);
    chk("t1_swap_pulse", 48'(swap_pulse), 48'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    repeat (3) tick();

    // T2: full frame with the scan running, then swap
    scan_en = 1'b1;
    write_pattern(0, 4095, 8'hA5);
    chk("t2_wr_ready_low", 48'(wr_ready), 48'd0);
    chk("t2_not_valid_yet", 48'(frame_valid), 48'd0);
    wait_swap(40, "t2_swap");
    scan_en = 1'b0;
    read_chk(5, 3, {8'd5, 8'd3, 8'hA5, 8'd5, 8'd35, 8'hA5}, "t2_rd53");
    rd_addrx = 6'd6;
    rd_addry = 5'd4;
    #2;
    chk("t2_latency", {r0, g0, b0, r1, g1, b1}, {8'd5, 8'd3, 8'hA5, 8'd5, 8'd35, 8'hA5});

    // T3: backpressure in WAIT, display unchanged until the next boundary
    rd_addry = 5'd10;
    for (int k = 0; k < 4096; k++) write_px(24'hFFFFFF, 1'b0);
    wr_valid = 1'b1;
    wr_data  = 24'h000000;
    repeat (100) tick();
    wr_valid = 1'b0;
    chk("t3_wr_ready_low", 48'(wr_ready), 48'd0);
    read_chk(5, 3, {8'd5, 8'd3, 8'hA5, 8'd5, 8'd35, 8'hA5}, "t3_still_t2");
    rd_addry = 5'd0;
    scan_en  = 1'b1;
    wait_swap(40, "t3_swap");
    scan_en = 1'b0;
    read_chk(5, 3, 48'hFFFFFF_FFFFFF, "t3_rd53");

    // T4: sof resync after a partial frame
    scan_en = 1'b1;
    write_pattern(0, 99, 8'h11);
    write_px(24'h123456, 1'b1);
    write_pattern(1, 4095, 8'hC3);
    wait_swap(40, "t4_swap");
    scan_en = 1'b0;
    read_chk(0, 0, {24'h123456, 8'd0, 8'd32, 8'hC3}, "t4_rd00");
    read_chk(5, 3, {8'd5, 8'd3, 8'hC3, 8'd5, 8'd35, 8'hC3}, "t4_rd53");
    read_chk(63, 31, {8'd63, 8'd31, 8'hC3, 8'd63, 8'd63, 8'hC3}, "t4_rd6331");

    // T5: last pixel accepted on the boundary cycle
    rd_addry = 5'd31;
    write_pattern(0, 4094, 8'h5A);
    rd_addry = 5'd0;
    write_px({8'd63, 8'd63, 8'h5A}, 1'b0);
    chk("t5_no_swap", 48'(swap_pulse), 48'd0);
    chk("t5_waiting", 48'(wr_ready), 48'd0);
    repeat (2) tick();
    read_chk(5, 3, {8'd5, 8'd3, 8'hC3, 8'd5, 8'd35, 8'hC3}, "t5_still_t4");
    rd_addry = 5'd1;
    scan_en  = 1'b1;
    wait_swap(40, "t5_swap");
    scan_en = 1'b0;
    read_chk(5, 3, {8'd5, 8'd3, 8'h5A, 8'd5, 8'd35, 8'h5A}, "t5_rd53");

    // T6: three scan frames without writes
    rd_addry = 5'd0;
    scan_en  = 1'b1;
    pulses   = 0;
    repeat (96) begin
      tick();
      if (swap_pulse) pulses++;
    end
    chk("t6_pulses", 48'(pulses), 48'd0);
    scan_en = 1'b0;
    read_chk(5, 3, {8'd5, 8'd3, 8'h5A, 8'd5, 8'd35, 8'h5A}, "t6_rd53");

    // Mid-frame reset drops the partial frame and blanks the outputs
    for (int k = 0; k < 50; k++) write_px(24'hFFFFFF, 1'b0);
    #3 reset = 1'b1;
    #1;
    chk("rst_colour", {r0, g0, b0, r1, g1, b1}, 48'd0);
    chk("rst_frame_valid", 48'(frame_valid), 48'd0);
    chk("rst_wr_ready", 48'(wr_ready), 48'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    repeat (3) tick();
    scan_en = 1'b1;
    write_pattern(0, 4095, 8'h77);
    wait_swap(40, "rst_swap");
    scan_en = 1'b0;
    read_chk(5, 3, {8'd5, 8'd3, 8'h77, 8'd5, 8'd35, 8'h77}, "rst_rd53");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
